fp_mul_iter_unit: RTL and testbench

FP_MUL_ITER_UNIT -- requirements
Module: fp_mul_iter_unit

---
 rtl/fp_mul_iter_unit.sv | 208 ++++++++++++++++++++
 tb/tb_fp_mul_iter_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_iter_unit.sv
// Iterative floating-point multiplier: radix-4 Booth significand product, then normalise/round.
// Build option: define FP_MUL_ROUND_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mul_iter_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clk_en_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [EXP_W+MAN_W:0] multiplier_i,
  input  logic [EXP_W+MAN_W:0] multiplicand_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [EXP_W+MAN_W:0] result_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  output logic                 invalid_op_o,
  output logic                 inexact_o
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int N  = (SW + 1) / 2;
  localparam int BW = 2 * N;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
`ifdef FP_MUL_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

  state_t                 r_state, w_stateNext;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_mplr;
  logic                   r_bPrev;
  logic [PW-1:0]          r_mcand, r_acc;
  logic                   r_sign;
  logic signed [XW-1:0]   r_exp;
  logic [W-1:0]           r_result;
  logic                   r_ovf, r_unf, r_inv, r_inx;

  logic                   w_sMr, w_sMd, w_sign;
  logic [EXP_W-1:0]       w_eMr, w_eMd;
  logic [MAN_W-1:0]       w_mMr, w_mMd;
  logic                   w_mrZero, w_mrInf, w_mrNan, w_mdZero, w_mdInf, w_mdNan;
  logic                   w_invalid, w_anyInf, w_anyZero, w_special;
  logic [W-1:0]           w_specialRes;
  logic signed [XW-1:0]   w_expSum;
  logic [BW-1:0]          w_mrInit;
  logic [PW-1:0]          w_mdInit, w_accInit, w_pp;

  logic                   w_high, w_guard, w_sticky, w_rndUp, w_carry, w_ovf, w_unf, w_inexact;
  logic [PW-1:0]          w_shifted;
  logic [SW-1:0]          w_kept, w_disc;
  logic [SW:0]            w_rounded;
  logic [MAN_W-1:0]       w_manOut;
  logic signed [XW-1:0]   w_expFinal;
  logic [W-1:0]           w_normRes;

  assign {w_sMr, w_eMr, w_mMr} = multiplier_i;
  assign {w_sMd, w_eMd, w_mMd} = multiplicand_i;
  assign w_sign    = w_sMr ^ w_sMd;
  assign w_mrZero  = (w_eMr == '0);
  assign w_mrInf   = (&w_eMr) & (w_mMr == '0);
  assign w_mrNan   = (&w_eMr) & (w_mMr != '0);
  assign w_mdZero  = (w_eMd == '0);
  assign w_mdInf   = (&w_eMd) & (w_mMd == '0);
  assign w_mdNan   = (&w_eMd) & (w_mMd != '0);
  assign w_invalid = w_mrNan | w_mdNan | (w_mrInf & w_mdZero) | (w_mdInf & w_mrZero);
  assign w_anyInf  = w_mrInf | w_mdInf;
  assign w_anyZero = w_mrZero | w_mdZero;
  assign w_special = w_invalid | w_anyInf | w_anyZero;
  assign w_expSum  = $signed({2'b00, w_eMr}) + $signed({2'b00, w_eMd}) - BIAS;

  always_comb begin
    w_specialRes = {w_sign, {(W-1){1'b0}}};
    if (w_invalid)
      w_specialRes = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (w_anyInf)
      w_specialRes = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  // When the recoded window's top bit is a real significand bit, Booth reads it as a sign; pre-add A<<BW to undo that.
  assign w_mrInit  = BW'({1'b1, w_mMr});
  assign w_mdInit  = PW'({1'b1, w_mMd});
  assign w_accInit = w_mrInit[BW-1] ? (w_mdInit << BW) : '0;

  always_comb begin
    w_pp = '0;
    case ({r_mplr[1:0], r_bPrev})
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = r_mcand << 1;
      3'b100:         w_pp = -(r_mcand << 1);
      3'b101, 3'b110: w_pp = -r_mcand;
      default:        w_pp = '0;
    endcase
  end

  assign w_high     = r_acc[PW-1];
  assign w_shifted  = w_high ? r_acc : (r_acc << 1);
  assign w_kept     = w_shifted[PW-1:SW];
  assign w_disc     = w_shifted[SW-1:0];
  assign w_guard    = w_disc[SW-1];
  assign w_sticky   = |w_disc[SW-2:0];
  assign w_rndUp    = ROUND_EN & w_guard & (w_sticky | w_kept[0]);
  assign w_inexact  = ROUND_EN & (|w_disc);
  assign w_rounded  = {1'b0, w_kept} + {{SW{1'b0}}, w_rndUp};
  assign w_carry    = w_rounded[SW];
  assign w_manOut   = w_carry ? w_rounded[MAN_W:1] : w_rounded[MAN_W-1:0];
  assign w_expFinal = r_exp + {{(XW-1){1'b0}}, w_high} + {{(XW-1){1'b0}}, w_carry};
  assign w_ovf      = (w_expFinal >= EXP_MAX);
  assign w_unf      = (w_expFinal < EXP_ONE);

  always_comb begin
    w_normRes = {r_sign, w_expFinal[EXP_W-1:0], w_manOut};
    if (w_ovf)
      w_normRes = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (w_unf)
      w_normRes = {r_sign, {(W-1){1'b0}}};
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (valid_i) w_stateNext = w_special ? DONE : MULT;
      MULT:    if (r_cnt == CW'(N - 1)) w_stateNext = NORM;
      NORM:    w_stateNext = DONE;
      DONE:    if (ready_i) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_state <= IDLE;
    else if (clk_en_i)
      r_state <= w_stateNext;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt    <= '0;
      r_mplr   <= '0;
      r_bPrev  <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inv    <= 1'b0;
      r_inx    <= 1'b0;
    end else if (clk_en_i) begin
      case (r_state)
        IDLE: if (valid_i) begin
          r_sign  <= w_sign;
          r_exp   <= w_expSum;
          r_mcand <= w_mdInit;
          r_mplr  <= w_mrInit;
          r_bPrev <= 1'b0;
          r_acc   <= w_accInit;
          r_cnt   <= '0;
          if (w_special) begin
            r_result <= w_specialRes;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inv    <= w_invalid;
            r_inx    <= 1'b0;
          end
        end
        MULT: begin
          r_acc   <= r_acc + w_pp;
          r_mcand <= r_mcand << 2;
          r_mplr  <= r_mplr >> 2;
          r_bPrev <= r_mplr[1];
          r_cnt   <= r_cnt + 1'b1;
        end
        NORM: begin
          r_result <= w_normRes;
          r_ovf    <= w_ovf;
          r_unf    <= ~w_ovf & w_unf;
          r_inv    <= 1'b0;
          r_inx    <= w_inexact;
        end
        default: ;
      endcase
    end
  end

  assign ready_o      = (r_state == IDLE);
  assign valid_o      = (r_state == DONE);
  assign result_o     = r_result;
  assign overflow_o   = r_ovf;
  assign underflow_o  = r_unf;
  assign invalid_op_o = r_inv;
  assign inexact_o    = r_inx;

endmodule

// File: tb/tb_fp_mul_iter_unit.sv
// Self-checking bench for fp_mul_iter_unit (single precision): directed table, hand sequences, random vs model.
module tb_fp_mul_iter_unit;

  localparam int LAT_NORMAL  = 13;
  // Special operands reach DONE on the transfer edge itself, so valid_o is already up one cycle later.
  localparam int LAT_SPECIAL = 0;
  localparam int WAIT_LIMIT  = 60;
  localparam int NUM_VEC     = 11;
  localparam int NUM_RAND    = 120;
`ifdef FP_MUL_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        clkEn, validIn, readyOut, validOut, readyIn;
  logic [31:0] mr, md, resOut;
  logic        ovf, unf, inv, inx;

  int nCompared = 0;
  int nMismatch = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    logic [3:0]  expFlags;
    int          expLat;
  } vec_t;

  vec_t vecs [NUM_VEC];

  fp_mul_iter_unit dut (
    .clk_i          (clk),
    .rst_n_i        (rstN),
    .clk_en_i       (clkEn),
    .valid_i        (validIn),
    .ready_o        (readyOut),
    .multiplier_i   (mr),
    .multiplicand_i (md),
    .valid_o        (validOut),
    .ready_i        (readyIn),
    .result_o       (resOut),
    .overflow_o     (ovf),
    .underflow_o    (unf),
    .invalid_op_o   (inv),
    .inexact_o      (inx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] flagsNow();
    return {28'h0, ovf, unf, inv, inx};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Flags are packed {overflow, underflow, invalid, inexact}.
  function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic [3:0] flags, output int lat);
    logic sign;
    int ea, eb, e, sh;
    logic [22:0] ma, mb;
    bit nanA, nanB, infA, infB, zeroA, zeroB;
    longint unsigned p, kept, rem, half;
    sign = a[31] ^ b[31];
    ea = int'(a[30:23]);  eb = int'(b[30:23]);
    ma = a[22:0];         mb = b[22:0];
    nanA = (ea == 255) && (ma != 0);  nanB = (eb == 255) && (mb != 0);
    infA = (ea == 255) && (ma == 0);  infB = (eb == 255) && (mb == 0);
    zeroA = (ea == 0);                zeroB = (eb == 0);
    flags = 4'b0000;
    lat = LAT_SPECIAL;
    if (nanA || nanB || (infA && zeroB) || (infB && zeroA)) begin
      res = 32'h7FC00000;
      flags = 4'b0010;
    end else if (infA || infB) begin
      res = {sign, 8'hFF, 23'h0};
    end else if (zeroA || zeroB) begin
      res = {sign, 31'h0};
    end else begin
      lat = LAT_NORMAL;
      p = (64'(ma) + 64'h80_0000) * (64'(mb) + 64'h80_0000);
      e = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e++;
      end else begin
        sh = 23;
      end
      kept = p >> sh;
      rem  = p - (kept << sh);
      half = 64'd1 << (sh - 1);
      if (ROUND && rem != 0) flags[0] = 1'b1;
      if (ROUND && (rem > half || (rem == half && kept[0]))) kept++;
      if (kept == (64'd1 << 24)) begin
        kept = kept >> 1;
        e++;
      end
      if (e >= 255) begin
        res = {sign, 8'hFF, 23'h0};
        flags[3] = 1'b1;
      end else if (e < 1) begin
        res = {sign, 31'h0};
        flags[2] = 1'b1;
      end else begin
        res = {sign, 8'(e), 23'(kept)};
      end
    end
  endfunction

  function automatic logic [31:0] randOperand();
    int mode;
    logic [31:0] v;
    mode = $urandom_range(0, 15);
    v = $urandom;
    if (mode == 0) v[30:23] = 8'h00;
    else if (mode == 1) v[30:23] = 8'hFF;
    else if (mode == 2) begin
      v[30:23] = 8'hFF;
      v[22:0] = 23'h0;
    end else if (mode == 3) begin
      v[30:23] = 8'($urandom_range(100, 150));
      v[15:0] = 16'h0;
    end else if (mode < 7) begin
      v = v;
    end else begin
      v[30:23] = 8'($urandom_range(70, 185));
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int stall, output int lat);
    mr = a;
    md = b;
    validIn = 1'b1;
    @(posedge clk); #1;
    validIn = 1'b0;
    lat = 0;
    if (stall > 0) begin
      clkEn = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
      clkEn = 1'b1;
      lat = stall;
    end
    while (!validOut && lat < WAIT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic releaseResult();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] a, b, expRes;
    logic [3:0] expFlags;
    int expLat;
    logic sawValid;

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_NORMAL};
    vecs[1]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0010, LAT_SPECIAL};
    vecs[2]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, LAT_SPECIAL};
    vecs[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b1000, LAT_NORMAL};
    vecs[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0100, LAT_NORMAL};
`ifdef FP_MUL_ROUND_EN
    vecs[5]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, LAT_NORMAL};
`else
    vecs[5]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00001, 4'b0000, LAT_NORMAL};
`endif
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0010, LAT_SPECIAL};
    vecs[7]  = '{32'h80000000, 32'h40400000, 32'h80000000, 4'b0000, LAT_SPECIAL};
    vecs[8]  = '{32'hC0000000, 32'h40000000, 32'hC0800000, 4'b0000, LAT_NORMAL};
    vecs[9]  = '{32'h007FFFFF, 32'h3F800000, 32'h00000000, 4'b0000, LAT_SPECIAL};
    vecs[10] = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000, LAT_SPECIAL};

    clkEn = 1'b1;
    validIn = 1'b0;
    readyIn = 1'b1;
    mr = 32'h0;
    md = 32'h0;
    #1 rstN = 1'b0;
    #2;
    checkOutput("reset ready_o", {31'h0, readyOut}, 32'h1);
    checkOutput("reset valid_o", {31'h0, validOut}, 32'h0);
    checkOutput("reset result_o", resOut, 32'h0);
    checkOutput("reset flags", flagsNow(), 32'h0);

    // First transfer happens on the very first edge after reset release.
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 0, lat);
      checkOutput($sformatf("vec%0d result", i), resOut, vecs[i].expRes);
      checkOutput($sformatf("vec%0d flags", i), flagsNow(), {28'h0, vecs[i].expFlags});
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
      releaseResult();
    end

    applyStimulus(32'h3FC00000, 32'h40000000, 3, lat);
    checkOutput("clk_en stall result", resOut, 32'h40400000);
    checkOutput("clk_en stall latency", 32'(lat), 32'(LAT_NORMAL + 3));
    releaseResult();

    readyIn = 1'b0;
    applyStimulus(32'h40400000, 32'h40000000, 0, lat);
    checkOutput("backpressure latency", 32'(lat), 32'(LAT_NORMAL));
    mr = 32'h3F800000;
    md = 32'h3F800000;
    validIn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d valid_o", k), {31'h0, validOut}, 32'h1);
      checkOutput($sformatf("hold%0d result_o", k), resOut, 32'h40C00000);
      checkOutput($sformatf("hold%0d ready_o", k), {31'h0, readyOut}, 32'h0);
    end
    validIn = 1'b0;
    readyIn = 1'b1;
    @(posedge clk); #1;
    checkOutput("release ready_o", {31'h0, readyOut}, 32'h1);
    checkOutput("release valid_o", {31'h0, validOut}, 32'h0);
    @(posedge clk); #1;
    checkOutput("ignored operand stays idle", {31'h0, readyOut}, 32'h1);

    mr = 32'h3FC00000;
    md = 32'h40000000;
    validIn = 1'b1;
    @(posedge clk); #1;
    validIn = 1'b0;
    repeat (4) @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    checkOutput("midreset valid_o", {31'h0, validOut}, 32'h0);
    checkOutput("midreset ready_o", {31'h0, readyOut}, 32'h1);
    checkOutput("midreset result_o", resOut, 32'h0);
    checkOutput("midreset flags", flagsNow(), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    sawValid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (validOut) sawValid = 1'b1;
    end
    checkOutput("no valid after reset", {31'h0, sawValid}, 32'h0);
    applyStimulus(32'h40000000, 32'h40000000, 0, lat);
    checkOutput("post-reset result", resOut, 32'h40800000);
    checkOutput("post-reset flags", flagsNow(), 32'h0);
    checkOutput("post-reset latency", 32'(lat), 32'(LAT_NORMAL));
    releaseResult();

    for (int i = 0; i < NUM_RAND; i++) begin
      a = randOperand();
      b = randOperand();
      refModel(a, b, expRes, expFlags, expLat);
      applyStimulus(a, b, 0, lat);
      checkOutput($sformatf("rand%0d %08h*%08h result", i, a, b), resOut, expRes);
      checkOutput($sformatf("rand%0d %08h*%08h flags", i, a, b), flagsNow(), {28'h0, expFlags});
      checkOutput($sformatf("rand%0d latency", i), 32'(lat), 32'(expLat));
      releaseResult();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
